// File: rtl/button_events_if.sv
// Event stream handshake between button_events and its consumer.
// master drives event_valid/event_data; slave drives event_ready.
interface button_events_if;
  logic       event_valid;
  logic [3:0] event_data;
  logic       event_ready;

  modport master (
    output event_valid,
    output event_data,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_data,
    output event_ready
  );
endinterface

// File: rtl/button_events.sv
// Debounces 8 raw buttons into state[] and queues press/release events.
// Ports: clock, reset_n, buttons_raw, state, ev (event stream), overflow(_clear).
module button_events #(
  parameter int TICK_CYCLES  = 5000,
  parameter int STABLE_TICKS = 10,
  parameter int ACTIVE_LOW   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [7:0]         buttons_raw,
  output logic [7:0]         state,
  button_events_if.master    ev,
  output logic               overflow,
  input  logic               overflow_clear
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  logic [7:0] sync1_q, sync2_q;
  logic [7:0] s;

  logic [3:0] cnt_q [8];
  logic [3:0] cnt_d [8];
  logic [7:0] state_q, state_d;
  logic [7:0] commit;

  logic [7:0] pend_q, pend_d;
  logic [7:0] pdir_q, pdir_d;
  logic       loss;

  logic [3:0] mem_q [FIFO_DEPTH];
  logic [3:0] mem_d [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] count, avail;
  logic        full, pop, wr;
  logic [2:0]  sel;

  logic       valid_q, valid_d;
  logic [3:0] data_q, data_d;
  logic       ovf_q, ovf_d;

  assign s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  assign tick    = presc_q == PW'(TICK_CYCLES - 1);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_comb begin
    state_d = state_q;
    commit  = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (s[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] + 4'd1 == 4'(STABLE_TICKS)) begin
          cnt_d[i]   = '0;
          state_d[i] = s[i];
          commit[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Lowest pending index wins: scan high to low, last hit sticks.
  always_comb begin
    sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) sel = 3'(i);
    end
  end

  assign count = wptr_q - rptr_q;
  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign pop   = valid_q & ev.event_ready;
  assign wr    = (|pend_q) & (~full | pop);
  assign avail = count - {{AW{1'b0}}, pop};

  always_comb begin
    pend_d = pend_q;
    pdir_d = pdir_q;
    loss   = 1'b0;
    if (wr) pend_d[sel] = 1'b0;
    // A commit only loses an event if the old one is still pending
    // after this cycle's arbiter write.
    for (int i = 0; i < 8; i++) begin
      if (commit[i]) begin
        if (pend_d[i]) loss = 1'b1;
        pend_d[i] = 1'b1;
        pdir_d[i] = state_d[i];
      end
    end
  end

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (wr) begin
      mem_d[wptr_q[AW-1:0]] = {pdir_q[sel], sel};
      wptr_d = wptr_q + (AW+1)'(1);
    end
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
    // Head register only sees entries written before this edge,
    // giving one clock of first-word latency.
    valid_d = avail != '0;
    data_d  = valid_d ? mem_q[rptr_d[AW-1:0]] : data_q;
  end

  always_comb begin
    ovf_d = overflow_clear ? 1'b0 : ovf_q;
    if (loss) ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= '0;
      pend_q  <= '0;
      pdir_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      presc_q <= presc_d;
      sync1_q <= buttons_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      pend_q  <= pend_d;
      pdir_q  <= pdir_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign state          = state_q;
  assign ev.event_valid = valid_q;
  assign ev.event_data  = data_q;
  assign overflow       = ovf_q;

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Input-side counterpart to the board LED driver. It takes 8 raw front-panel push-buttons/switches, synchronises and debounces them, and publishes the debounced level vector.
- Each debounced press or release is also queued as an event, which the CPU-side register interface drains over a valid/ready handshake.
- It sits next to the LED block in the board-support logic.

Parameters:
- TICK_CYCLES, 5000: clocks per debounce sample tick (1 ms at 5 MHz); minimum 2.
- STABLE_TICKS, 10: consecutive agreeing samples a channel needs before it commits a new level; range 1–15.
- ACTIVE_LOW, 1: 1 means raw inputs read 0 when pressed and are inverted after the synchroniser.
- FIFO_DEPTH, 4: event queue entries; must be a power of two, at least 2.

Ports:
- clock, in, 1: system clock.
- reset_n, in, 1: synchronous, active-low reset.
- buttons_raw, in, 8: asynchronous raw button pins.
- state, out, 8: debounced levels, 1 = pressed.
- event_valid, out, 1: head of the queue is valid.
- event_data, out, 4: event code. Bit 3 is 1 for press, 0 for release. Bits 2:0 are the channel index.
- event_ready, in, 1: consumer accepts the head event.
- overflow, out, 1: sticky flag; an event was lost.
- overflow_clear, in, 1: clears overflow.

Behaviour:
- Reset (reset_n low at a clock edge) clears the following to 0: state, event_valid, event_data, overflow, the synchronisers, per-channel counters, pending bits, FIFO pointers and the tick prescaler. Any event in the queue is discarded.
- Synchroniser: a 2-FF synchroniser per bit, then optional inversion. Call the result s[i].
- Prescaler: counts 0..TICK_CYCLES-1 and asserts tick for one clock when the count equals TICK_CYCLES-1, then wraps to 0.
- Per-channel debounce, evaluated only on tick:
  - If s[i] equals state[i], cnt[i] is set to 0.
  - Otherwise cnt[i] increments.
  - When the incremented value equals STABLE_TICKS: cnt[i] is set to 0, state[i] takes s[i] at that clock edge, and a change is committed.
  - A glitch shorter than STABLE_TICKS ticks never changes state.
- Pending stage: a commit sets pend[i] and records pdir[i] = new state[i].
  - If pend[i] is already set at commit time, pdir[i] is overwritten, pend[i] stays set, and overflow is set.
- Arbiter: each clock, if a pend bit is set and the FIFO is not full (after accounting for a same-cycle pop), the lowest-index pend[i] is written to the FIFO as {pdir[i], i}. That pend[i] is cleared on the same edge.
  - At most one write per clock.
  - Simultaneous commits on several channels therefore enqueue in ascending index order on consecutive clocks.
- FIFO:
  - event_valid is high whenever the FIFO is non-empty, and event_data is the head entry (registered outputs).
  - A pop occurs when event_valid and event_ready are both high at a clock edge.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - A write into an empty FIFO makes event_valid high on the following clock (first-word latency is 1 clock after the arbiter write).
  - While the FIFO is full with no pop, pend bits are held, not dropped; loss happens only through the pend overwrite rule.
- Overflow: sticky. overflow_clear deasserts it on the next edge, unless a new loss occurs in that same cycle, in which case it stays 1.
- Overall latency: from a raw edge to state change is 2 synchroniser clocks, plus the wait for the next tick, plus STABLE_TICKS-1 further ticks. The event appears on event_valid 2 clocks after the state change (pend, then FIFO write, then valid).
- Reset asserted mid-debounce or mid-queue abandons all in-progress work.
  - After reset, a button held down is reported as a press event once it has been stable for STABLE_TICKS ticks.

Test Plan:
All scenarios use TICK_CYCLES=4, STABLE_TICKS=3, ACTIVE_LOW=1, FIFO_DEPTH=4, with event_ready held high unless stated.
- Clean press: drive buttons_raw[2] to 0 and hold. Expect state=8'h04 after 3 ticks, then exactly one event of 4'hA, then state holds.
- Glitch rejection: pulse buttons_raw[5] low for 2 ticks, then release. Expect state to stay 0, no event_valid, and cnt[5] to return to 0.
- Simultaneous commit: press channels 7, 0 and 3 on the same clock. Expect events 4'h8, 4'hB, 4'hF on three consecutive pops, with state=8'h89.
- FIFO full and overflow:
  - Hold event_ready at 0 and generate 5 press commits on channels 0–4. Expect 4 entries queued, pend[4] held, overflow still 0.
  - Then release and re-press channel 4 while it is pending. Expect overflow=1, and pend[4] to be a press (pdir=1) after the overwrite.
  - Assert overflow_clear. Expect overflow=0 on the next clock.
- Push and pop while full: with the FIFO full and one pend bit set, pulse event_ready for 1 clock. Expect the head to pop and the pending event to be written the same cycle, leaving count at 4.
- Reset mid-operation: assert reset_n=0 with 2 events queued and channel 6 mid-debounce, while channel 1 is held pressed.
  - Expect event_valid=0, state=0 and overflow=0 on the next clock.
  - After release of reset, expect 4'h9 once 3 ticks have elapsed and no event for channel 6.
